// File: rtl/alu_pkg.sv
// Shared opcode constants, default widths and the command record for the ALU issue stage.
// The command record carries a tag field only when ALU_ISSUE_TAG_EN is defined.
package alu_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int SEL_W_DEF  = 4;

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_DIV  = 4'h2;
   localparam logic [3:0] OP_AND  = 4'h8;
   localparam logic [3:0] OP_OR   = 4'h9;
   localparam logic [3:0] OP_XOR  = 4'hA;
   localparam logic [3:0] OP_NOTB = 4'hF;

   typedef struct packed {
`ifdef ALU_ISSUE_TAG_EN
      logic [3:0]            tag;
`endif
      logic [SEL_W_DEF-1:0]  sel;
      logic [DATA_W_DEF-1:0] a;
      logic [DATA_W_DEF-1:0] b;
   } cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Parameterised synchronous FIFO holding packed issue commands.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module alu_cmd_fifo #(
   parameter int W     = 20,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic         full,
   output logic         empty,
   output logic [W-1:0] head
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;
   logic         do_push;
   logic         do_pop;

   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/alu_issue_stage.sv
// Command FIFO -> registered ALU operands (EX) -> captured result (RES) with valid/ready output.
// Optional ALU_ISSUE_TAG_EN adds a 4-bit tag carried alongside each command.
module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int SEL_W      = SEL_W_DEF,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [DATA_W-1:0] cmd_a,
   input  logic [DATA_W-1:0] cmd_b,
   input  logic [SEL_W-1:0]  cmd_sel,
`ifdef ALU_ISSUE_TAG_EN
   input  logic [3:0]        cmd_tag,
   output logic [3:0]        res_tag,
`endif
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [SEL_W-1:0]  alu_sel,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_carryout,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [DATA_W-1:0] res_data,
   output logic              res_carry,
   output logic              res_err,
   output logic              busy
);

`ifdef ALU_ISSUE_TAG_EN
   localparam int TAG_W = 4;
`else
   localparam int TAG_W = 0;
`endif
   localparam int CMD_W = TAG_W + SEL_W + 2*DATA_W;

   logic [CMD_W-1:0]  fifo_din;
   logic [CMD_W-1:0]  fifo_head;
   logic              fifo_full;
   logic              fifo_empty;
   logic              push;
   logic              pop;
   logic              ex_vld;
   logic              ex_adv;
   logic              div_zero;
   logic [DATA_W-1:0] head_a;
   logic [DATA_W-1:0] head_b;
   logic [SEL_W-1:0]  head_sel;

`ifdef ALU_ISSUE_TAG_EN
   logic [3:0] head_tag;
   logic [3:0] ex_tag;
   assign fifo_din = {cmd_tag, cmd_sel, cmd_a, cmd_b};
   assign {head_tag, head_sel, head_a, head_b} = fifo_head;
`else
   assign fifo_din = {cmd_sel, cmd_a, cmd_b};
   assign {head_sel, head_a, head_b} = fifo_head;
`endif

   // Full means no acceptance even when a pop frees a slot in the same cycle.
   assign cmd_ready = !fifo_full;
   assign push      = cmd_valid && cmd_ready;
   assign ex_adv    = ex_vld && (!res_valid || res_ready);
   assign pop       = !fifo_empty && (!ex_vld || ex_adv);
   assign div_zero  = (alu_sel == SEL_W'(OP_DIV)) && (alu_b == '0);
   assign busy      = !fifo_empty || ex_vld || res_valid;

   alu_cmd_fifo #(
      .W     (CMD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .push  (push),
      .pop   (pop),
      .din   (fifo_din),
      .full  (fifo_full),
      .empty (fifo_empty),
      .head  (fifo_head)
   );

   // EX stage: operands held on the ALU inputs; flush clears only the valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_vld  <= 1'b0;
         alu_a   <= '0;
         alu_b   <= '0;
         alu_sel <= '0;
`ifdef ALU_ISSUE_TAG_EN
         ex_tag  <= '0;
`endif
      end else if (flush) begin
         ex_vld <= 1'b0;
      end else if (pop) begin
         ex_vld  <= 1'b1;
         alu_a   <= head_a;
         alu_b   <= head_b;
         alu_sel <= head_sel;
`ifdef ALU_ISSUE_TAG_EN
         ex_tag  <= head_tag;
`endif
      end else if (ex_adv) begin
         ex_vld <= 1'b0;
      end
   end

   // RES stage: capture the ALU output with carry/divide-by-zero qualification.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_valid <= 1'b0;
         res_data  <= '0;
         res_carry <= 1'b0;
         res_err   <= 1'b0;
`ifdef ALU_ISSUE_TAG_EN
         res_tag   <= '0;
`endif
      end else if (flush) begin
         res_valid <= 1'b0;
         res_data  <= '0;
         res_carry <= 1'b0;
         res_err   <= 1'b0;
`ifdef ALU_ISSUE_TAG_EN
         res_tag   <= '0;
`endif
      end else if (ex_adv) begin
         res_valid <= 1'b1;
         res_data  <= div_zero ? '1 : alu_result;
         res_carry <= (alu_sel == SEL_W'(OP_ADD)) ? alu_carryout : 1'b0;
         res_err   <= div_zero;
`ifdef ALU_ISSUE_TAG_EN
         res_tag   <= ex_tag;
`endif
      end else if (res_valid && res_ready) begin
         res_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage with a behavioural ALU and a result scoreboard.
// Tag checks are active when ALU_ISSUE_TAG_EN is defined.
module tb_alu_issue_stage;
   import alu_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       flush = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [7:0] cmd_a = '0;
   logic [7:0] cmd_b = '0;
   logic [3:0] cmd_sel = '0;
   logic [3:0] cmd_tag = '0;
   logic [3:0] res_tag;
   logic [7:0] alu_a, alu_b, alu_result;
   logic [3:0] alu_sel;
   logic       alu_carryout;
   logic       res_valid;
   logic       res_ready = 1'b1;
   logic [7:0] res_data;
   logic       res_carry, res_err, busy;

   int errors = 0;
   int checks = 0;
   bit mon_en = 1'b0;

   always #5 clk = ~clk;

   alu_issue_stage dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush        (flush),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_a        (cmd_a),
      .cmd_b        (cmd_b),
      .cmd_sel      (cmd_sel),
`ifdef ALU_ISSUE_TAG_EN
      .cmd_tag      (cmd_tag),
      .res_tag      (res_tag),
`endif
      .alu_a        (alu_a),
      .alu_b        (alu_b),
      .alu_sel      (alu_sel),
      .alu_result   (alu_result),
      .alu_carryout (alu_carryout),
      .res_valid    (res_valid),
      .res_ready    (res_ready),
      .res_data     (res_data),
      .res_carry    (res_carry),
      .res_err      (res_err),
      .busy         (busy)
   );

`ifndef ALU_ISSUE_TAG_EN
   assign res_tag = 4'h0;
`endif

   // Behavioural stand-in for the combinational ALU; 4'hE returns an arbitrary pattern.
   function automatic logic [7:0] alu_f(logic [3:0] s, logic [7:0] a, logic [7:0] b);
      case (s)
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_DIV:  return (b == 8'd0) ? 8'h00 : a / b;
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_XOR:  return a ^ b;
         OP_NOTB: return ~b;
         default: return 8'h5A;
      endcase
   endfunction

   always_comb begin
      alu_result   = alu_f(alu_sel, alu_a, alu_b);
      alu_carryout = ((9'(alu_a) + 9'(alu_b)) > 9'd255);
   end

   typedef struct {
      logic [7:0] data;
      logic       carry;
      logic       err;
      logic [3:0] tag;
   } exp_t;

   exp_t sbq[$];

   function automatic exp_t model(logic [3:0] s, logic [7:0] a, logic [7:0] b, logic [3:0] t);
      exp_t e;
      int   sum;
      sum     = int'(a) + int'(b);
      e.err   = (s == OP_DIV) && (b == 8'd0);
      e.data  = e.err ? 8'hFF : alu_f(s, a, b);
      e.carry = (s == OP_ADD) && (sum > 255);
`ifdef ALU_ISSUE_TAG_EN
      e.tag   = t;
`else
      e.tag   = 4'h0;
`endif
      return e;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard: record accepted commands and compare delivered results in order.
   always @(negedge clk) begin
      if (mon_en && rst_n && !flush) begin
         if (cmd_valid && cmd_ready) sbq.push_back(model(cmd_sel, cmd_a, cmd_b, cmd_tag));
         if (res_valid && res_ready) begin
            if (sbq.size() == 0) begin
               check("sb_unexpected_result", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = sbq.pop_front();
               check("sb_data", 32'(res_data), 32'(e.data));
               check("sb_carry", 32'(res_carry), 32'(e.carry));
               check("sb_err", 32'(res_err), 32'(e.err));
`ifdef ALU_ISSUE_TAG_EN
               check("sb_tag", 32'(res_tag), 32'(e.tag));
`endif
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_one(string name, logic [3:0] s, logic [7:0] a, logic [7:0] b,
                          logic [7:0] ed, logic ec, logic ee);
      int lat;
      cmd_valid = 1'b1; cmd_sel = s; cmd_a = a; cmd_b = b; cmd_tag = 4'h0;
      res_ready = 1'b1;
      check({name, "_ready"}, 32'(cmd_ready), 32'd1);
      step();
      cmd_valid = 1'b0;
      lat = 0;
      while (!res_valid && lat < 10) begin
         step();
         lat++;
      end
      check({name, "_latency"}, 32'(lat), 32'd2);
      check({name, "_data"}, 32'(res_data), 32'(ed));
      check({name, "_carry"}, 32'(res_carry), 32'(ec));
      check({name, "_err"}, 32'(res_err), 32'(ee));
      step();
      check({name, "_drained"}, 32'(busy), 32'd0);
   endtask

   typedef struct {
      logic [3:0] sel;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] data;
      logic       carry;
      logic       err;
   } vec_t;

   vec_t vt[10];

   initial begin
      int acc, run, n;
      vt[0] = '{OP_ADD,  8'hF0, 8'h20, 8'h10, 1'b1, 1'b0};
      vt[1] = '{OP_DIV,  8'd9,  8'd0,  8'hFF, 1'b0, 1'b1};
      vt[2] = '{OP_DIV,  8'd9,  8'd2,  8'd4,  1'b0, 1'b0};
      vt[3] = '{OP_SUB,  8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
      vt[4] = '{OP_ADD,  8'h01, 8'h02, 8'h03, 1'b0, 1'b0};
      vt[5] = '{OP_AND,  8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0};
      vt[6] = '{OP_XOR,  8'hFF, 8'h0F, 8'hF0, 1'b0, 1'b0};
      vt[7] = '{OP_NOTB, 8'h77, 8'h0F, 8'hF0, 1'b0, 1'b0};
      vt[8] = '{4'hE,    8'h12, 8'h34, 8'h5A, 1'b0, 1'b0};
      vt[9] = '{OP_SUB,  8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};

      #1;
      check("rst_res_valid", 32'(res_valid), 32'd0);
      check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      step();
      rst_n = 1'b1;
      step();

      foreach (vt[i]) run_one($sformatf("vec%0d", i), vt[i].sel, vt[i].a, vt[i].b,
                              vt[i].data, vt[i].carry, vt[i].err);

      // Async reset in the middle of a stream with commands still queued.
      res_ready = 1'b0;
      cmd_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cmd_sel = OP_ADD; cmd_a = 8'(i + 1); cmd_b = 8'h11;
         step();
      end
      cmd_valid = 1'b0;
      check("pre_rst_busy", 32'(busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid_res_valid", 32'(res_valid), 32'd0);
      check("rst_mid_busy", 32'(busy), 32'd0);
      check("rst_mid_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_mid_alu", 32'({alu_a, alu_b, alu_sel}), 32'd0);
      check("rst_mid_res", 32'({res_data, res_carry, res_err, res_tag}), 32'd0);
      step();
      rst_n = 1'b1;
      res_ready = 1'b1;
      step();
      check("post_rst_busy", 32'(busy), 32'd0);

      // Backpressure: four FIFO slots plus EX and RES absorb six commands.
      mon_en = 1'b1;
      res_ready = 1'b0;
      acc = 0;
      cmd_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cmd_sel = OP_ADD; cmd_a = 8'($urandom); cmd_b = 8'($urandom);
         if (cmd_ready) acc++;
         step();
      end
      cmd_valid = 1'b0;
      check("bp_accepted", 32'(acc), 32'd6);
      check("bp_cmd_ready_low", 32'(cmd_ready), 32'd0);
      res_ready = 1'b1;
      run = 0;
      while (res_valid && run < 20) begin
         step();
         run++;
      end
      check("bp_burst_len", 32'(run), 32'd6);
      check("bp_sb_empty", 32'(sbq.size()), 32'd0);
      mon_en = 1'b0;

      // Flush with two entries queued, EX loaded and RES holding a result.
      res_ready = 1'b0;
      cmd_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cmd_sel = OP_SUB; cmd_a = 8'(10 + i); cmd_b = 8'd1;
         step();
      end
      cmd_valid = 1'b0;
      check("pre_flush_res_valid", 32'(res_valid), 32'd1);
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("flush_res_valid", 32'(res_valid), 32'd0);
      check("flush_busy", 32'(busy), 32'd0);
      check("flush_cmd_ready", 32'(cmd_ready), 32'd1);
      check("flush_res_data", 32'(res_data), 32'd0);
      run_one("post_flush", OP_ADD, 8'h80, 8'h80, 8'h00, 1'b1, 1'b0);

      // Tagged SUB/AND/XOR sequence, then randomized traffic, all scoreboarded.
      mon_en = 1'b1;
      res_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cmd_valid = 1'b1;
         cmd_sel = (i == 0) ? OP_SUB : (i == 1) ? OP_AND : OP_XOR;
         cmd_a = 8'h3C + 8'(i); cmd_b = 8'h0F;
         cmd_tag = 4'(i + 1);
         step();
      end
      cmd_valid = 1'b0;
      for (int i = 0; i < 400; i++) begin
         logic [3:0] ops [8];
         ops = '{OP_ADD, OP_SUB, OP_DIV, OP_AND, OP_OR, OP_XOR, OP_NOTB, 4'hE};
         cmd_valid = ($urandom_range(0, 2) != 0);
         cmd_sel   = ops[$urandom_range(0, 7)];
         cmd_a     = 8'($urandom);
         cmd_b     = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
         cmd_tag   = 4'($urandom);
         res_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      cmd_valid = 1'b0;
      res_ready = 1'b1;
      n = 0;
      while (busy && n < 50) begin
         step();
         n++;
      end
      check("rand_drained", 32'(busy), 32'd0);
      check("rand_sb_empty", 32'(sbq.size()), 32'd0);
      mon_en = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
